jpeg_rle_expander: RTL and testbench

- Decoder side of the JPEG entropy path: expands one 8x8 block's stream of (run, size, amplitude) symbols into 64 zig-zag-ordered coefficients.
- Emits one coefficient per cycle.
- Sits between the Huffman symbol decoder upstream and the dequantiser/de-zigzag stage downstream.
- Inverse of the encoder-side run-length/category packer.

---
 rtl/jpeg_rle_expander.sv | 158 +++++++++++++++
 tb/tb_jpeg_rle_expander.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_rle_expander.sv
// JPEG run-length expander: turns one block's (run, size, amplitude) symbols
// into 64 zig-zag ordered coefficients, one per cycle, through a single output register.
module jpeg_rle_expander #(
  parameter int COEF_W    = 12,
  parameter int BLOCK_LEN = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_run,
  input  logic [3:0]               in_size,
  input  logic [10:0]              in_amp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [COEF_W-1:0] out_coef,
  output logic [5:0]               out_index,
  output logic                     out_last,
  output logic                     err_overrun
);

  typedef enum logic [2:0] {S_DC, S_AC, S_RUN, S_VAL, S_FILL} state_t;

  localparam logic [5:0] LAST_IDX  = 6'(BLOCK_LEN - 1);
  localparam logic [7:0] BLOCK_CNT = 8'(BLOCK_LEN);

  // JPEG amplitude category decode: a clear top bit marks a negative value
  // stored as amp - (2^size - 1).
  function automatic logic signed [COEF_W-1:0] amp_decode(input logic [3:0] size,
                                                          input logic [10:0] amp);
    logic [15:0] mask;
    logic [15:0] raw;
    logic [15:0] res;
    mask = (16'd1 << size) - 16'd1;
    raw  = {5'd0, amp} & mask;
    if (size == 4'd0) begin
      res = 16'd0;
    end else if (raw[size - 4'd1]) begin
      res = raw;
    end else begin
      res = raw - mask;
    end
    return COEF_W'($signed(res));
  endfunction

  state_t                    r_state;
  logic [5:0]                r_pos;
  logic [3:0]                r_zcnt;
  logic                      r_pend;
  logic signed [COEF_W-1:0]  r_pval;
  logic                      r_out_valid;
  logic signed [COEF_W-1:0]  r_out_coef;
  logic [5:0]                r_out_index;
  logic                      r_out_last;
  logic                      r_err;

  logic                      w_adv;
  logic                      w_xfer;
  logic                      w_emit;
  logic                      w_at_end;
  logic                      w_is_eob;
  logic                      w_is_zrl;
  logic                      w_overrun;
  logic [7:0]                w_need;
  logic signed [COEF_W-1:0]  w_v;

  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = !rst && w_adv && (r_state == S_DC || r_state == S_AC);
  assign w_xfer    = in_valid && in_ready;
  assign w_emit    = w_xfer || r_state == S_RUN || r_state == S_VAL || r_state == S_FILL;
  assign w_at_end  = (r_pos == LAST_IDX);
  assign w_is_eob  = (in_run == 4'd0) && (in_size == 4'd0);
  assign w_is_zrl  = (in_run == 4'd15) && (in_size == 4'd0);
  assign w_v       = amp_decode(in_size, in_amp);
  // Positions the symbol would consume, counting the first zero or value at r_pos.
  assign w_need    = {2'b00, r_pos} + (w_is_zrl ? 8'd16 : ({4'd0, in_run} + 8'd1));
  assign w_overrun = !w_is_eob && (w_need > BLOCK_CNT);

  assign out_valid   = r_out_valid;
  assign out_coef    = r_out_coef;
  assign out_index   = r_out_index;
  assign out_last    = r_out_last;
  assign err_overrun = r_err;

  // Expansion FSM: every emitting state writes the coefficient at r_pos, so an
  // accepted symbol produces its first output on the very next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_DC;
      r_pos       <= 6'd0;
      r_zcnt      <= 4'd0;
      r_pend      <= 1'b0;
      r_pval      <= '0;
      r_out_valid <= 1'b0;
      r_out_coef  <= '0;
      r_out_index <= 6'd0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_out_coef  <= '0;
        r_out_index <= r_pos;
        r_out_last  <= w_at_end;
        r_pos       <= w_at_end ? 6'd0 : r_pos + 6'd1;
        case (r_state)
          S_DC: begin
            r_out_coef <= w_v;
            r_state    <= S_AC;
          end
          S_AC: begin
            if (w_overrun) begin
              r_err   <= 1'b1;
              r_state <= S_FILL;
            end else if (w_is_eob) begin
              r_state <= S_FILL;
            end else if (w_is_zrl) begin
              r_zcnt  <= 4'd15;
              r_pend  <= 1'b0;
              r_state <= S_RUN;
            end else if (in_run == 4'd0) begin
              r_out_coef <= w_v;
              r_state    <= S_AC;
            end else begin
              r_zcnt  <= in_run - 4'd1;
              r_pend  <= 1'b1;
              r_pval  <= w_v;
              r_state <= (in_run == 4'd1) ? S_VAL : S_RUN;
            end
          end
          S_RUN: begin
            r_zcnt <= r_zcnt - 4'd1;
            if (r_zcnt == 4'd1) begin
              r_state <= r_pend ? S_VAL : S_AC;
            end else begin
              r_state <= S_RUN;
            end
          end
          S_VAL: begin
            r_out_coef <= r_pval;
            r_state    <= S_AC;
          end
          S_FILL: begin
            r_state <= S_FILL;
          end
          default: begin
            r_state <= S_DC;
          end
        endcase
        // Index 63 closes the block whatever state produced it.
        if (w_at_end) begin
          r_state <= S_DC;
        end
      end
    end
  end

endmodule

// File: tb/tb_jpeg_rle_expander.sv
// Self-checking bench for jpeg_rle_expander: a symbol-level model predicts
// the coefficient stream, and one compare process checks every accepted output.
module tb_jpeg_rle_expander;

  localparam int COEF_W = 12;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [3:0]               in_run = 4'd0;
  logic [3:0]               in_size = 4'd0;
  logic [10:0]              in_amp = 11'd0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [COEF_W-1:0] out_coef;
  logic [5:0]               out_index;
  logic                     out_last;
  logic                     err_overrun;

  jpeg_rle_expander #(.COEF_W(COEF_W), .BLOCK_LEN(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_run(in_run), .in_size(in_size), .in_amp(in_amp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_coef(out_coef), .out_index(out_index), .out_last(out_last),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit rnd_ready = 1'b0;

  int q_coef[$];
  int q_idx[$];
  int q_last[$];
  int m_pos = -1;
  bit m_err = 1'b0;

  int cap[64];
  int cap_last[64];
  int cyc_at[64];

  task automatic chk(input string nm, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Value of an amplitude category: upper half of the range is positive,
  // lower half maps to the negative range.
  function automatic int mdec(input int size, input int amp);
    int a;
    if (size == 0) return 0;
    a = amp % (1 << size);
    if (a >= (1 << (size - 1))) return a;
    return a - ((1 << size) - 1);
  endfunction

  task automatic mpush(input int c);
    q_coef.push_back(c);
    q_idx.push_back(m_pos);
    q_last.push_back(m_pos == 63 ? 1 : 0);
    m_pos++;
    if (m_pos == 64) m_pos = -1;
  endtask

  task automatic model_sym(input int run, input int size, input int amp);
    int zeros;
    int pend;
    if (m_pos < 0) begin
      m_pos = 0;
      mpush(mdec(size, amp));
    end else if (run == 0 && size == 0) begin
      do mpush(0); while (m_pos != -1);
    end else begin
      zeros = (run == 15 && size == 0) ? 16 : run;
      pend  = (run == 15 && size == 0) ? 0 : 1;
      if (m_pos + zeros + pend > 64) begin
        m_err = 1'b1;
        do mpush(0); while (m_pos != -1);
      end else begin
        repeat (zeros) mpush(0);
        if (pend != 0) mpush(mdec(size, amp));
      end
    end
  endtask

  task automatic send(input int run, input int size, input int amp);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_run   = run[3:0];
    in_size  = size[3:0];
    in_amp   = amp[10:0];
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    else model_sym(run, size, amp);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q_coef.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_queue_empty", q_coef.size(), 0);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1 out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  bit                       stall_prev = 1'b0;
  logic signed [COEF_W-1:0] p_coef;
  logic [5:0]               p_index;
  logic                     p_last;

  // Single compare process: handshakes against the model, holds during stalls.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_coef", out_coef, p_coef);
        chk("stall_hold_index", out_index, p_index);
        chk("stall_hold_last", out_last, p_last);
      end
      if (out_valid && !out_ready) chk("no_accept_while_stalled", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q_coef.size() == 0) begin
          chk("output_without_expectation", q_coef.size(), 1);
        end else begin
          chk("coef", $signed(out_coef), q_coef.pop_front());
          chk("index", out_index, q_idx.pop_front());
          chk("last", out_last, q_last.pop_front());
          cap[out_index]      = $signed(out_coef);
          cap_last[out_index] = out_last;
          cyc_at[out_index]   = cyc;
        end
      end
      stall_prev = out_valid && !out_ready;
      p_coef  = out_coef;
      p_index = out_index;
      p_last  = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gp;
    int r;
    int n;
    int nsym;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_coef", out_coef, 0);
    chk("reset_out_index", out_index, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_err", err_overrun, 0);
    chk("reset_in_ready_low", in_ready, 0);
    rst = 1'b0;

    // DC only: -5 then 63 zeros with no gaps
    send(0, 3, 3'b010);
    send(0, 0, 0);
    drain();
    chk("dc_only_idx0", cap[0], -5);
    chk("dc_only_idx63", cap[63], 0);
    chk("dc_only_last63", cap_last[63], 1);
    chk("dc_only_no_gaps", cyc_at[63] - cyc_at[0], 63);

    // Mixed symbols
    send(0, 2, 2'b11);
    send(2, 1, 0);
    send(15, 0, 0);
    send(0, 4, 4'b1010);
    send(0, 0, 0);
    drain();
    chk("mixed_idx0", cap[0], 3);
    chk("mixed_idx2", cap[2], 0);
    chk("mixed_idx3", cap[3], -1);
    chk("mixed_idx19", cap[19], 0);
    chk("mixed_idx20", cap[20], 10);
    chk("mixed_idx21", cap[21], 0);

    // Exact fill without EOB, then the next symbol is a DC
    send(0, 5, 5'b10100);
    repeat (3) send(15, 0, 0);
    send(14, 1, 1);
    drain();
    chk("fill_idx0", cap[0], 20);
    chk("fill_idx62", cap[62], 0);
    chk("fill_idx63", cap[63], 1);
    chk("fill_last63", cap_last[63], 1);
    chk("fill_no_err", err_overrun, 0);
    send(0, 2, 2'b01);
    send(0, 0, 0);
    drain();
    chk("after_fill_dc", cap[0], -2);

    // Overrun: fourth ZRL would reach position 65
    send(0, 1, 0);
    repeat (4) send(15, 0, 0);
    drain();
    chk("overrun_err", err_overrun, m_err);
    chk("overrun_err_set", err_overrun, 1);
    chk("overrun_idx48", cap[48], 0);
    chk("overrun_idx63", cap[63], 0);
    chk("overrun_last63", cap_last[63], 1);
    send(0, 4, 15);
    send(1, 2, 2'b10);
    send(0, 0, 0);
    drain();
    chk("post_overrun_idx0", cap[0], 15);
    chk("post_overrun_idx2", cap[2], 2);
    chk("post_overrun_err_sticky", err_overrun, 1);

    // Backpressure over 20 random blocks
    rnd_ready = 1'b1;
    for (int b = 0; b < 20; b++) begin
      send(0, $urandom_range(0, 11), $urandom_range(0, 2047));
      gp = 1;
      nsym = $urandom_range(0, 12);
      for (int k = 0; k < nsym; k++) begin
        if (gp >= 64) break;
        if (gp + 16 <= 64 && $urandom_range(0, 5) == 0) begin
          send(15, 0, 0);
          gp += 16;
        end else begin
          r = $urandom_range(0, 15);
          if (gp + r + 1 > 64) r = 64 - gp - 1;
          send(r, $urandom_range(1, 10), $urandom_range(0, 2047));
          gp += r + 1;
        end
      end
      if (gp < 64) send(0, 0, 0);
    end
    drain();
    rnd_ready = 1'b0;

    // Reset in the middle of a block
    send(0, 3, 3'b101);
    send(0, 0, 0);
    n = 0;
    while (!(out_valid && out_ready && out_index == 6'd30) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reached_index30", out_index, 30);
    @(posedge clk);
    #1 rst = 1'b1;
    q_coef.delete();
    q_idx.delete();
    q_last.delete();
    m_pos = -1;
    m_err = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_reset_out_valid", out_valid, 0);
    chk("mid_reset_err", err_overrun, 0);
    chk("mid_reset_index", out_index, 0);
    send(0, 2, 2'b01);
    send(0, 0, 0);
    drain();
    chk("after_reset_dc", cap[0], -2);
    chk("after_reset_idx30", cap[30], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
